// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the life-result frame receiver.
//   PERIOD_DEF  default UART bit time in clocks
//   HDR_DEF     frame header byte
//   nbytes()    payload length in bytes for a given grid edge
//   bit_state_t / frame_state_t  FSM encodings
package life_pkg;

    localparam int         PERIOD_DEF = 434;
    localparam logic [7:0] HDR_DEF    = 8'h4C;

    // Payload is INIT*INIT pattern bits plus a 32-bit count, rounded up to bytes.
    function automatic int nbytes(input int init);
        return (init * init + 32 + 7) / 8;
    endfunction

    // BS_WAIT holds off re-arming after a stop sample until the line is high.
    typedef enum logic [2:0] {
        BS_IDLE,
        BS_START,
        BS_DATA,
        BS_STOP,
        BS_WAIT
    } bit_state_t;

    typedef enum logic {
        FS_HUNT,
        FS_PAYLOAD
    } frame_state_t;

endpackage

// File: rtl/life_frame_rx_if.sv
// life_frame_rx_if: UART line in, result frame out.
//   rx         UART line, idle high
//   data       last complete payload (W bits)
//   valid      one-cycle strobe, data just updated
//   frame_err  one-cycle strobe, bad stop bit or inter-byte timeout
//   brk        one-cycle strobe, line held low through a full character
// modport slave = receiver side, master = line driver / result consumer.
interface life_frame_rx_if #(
    parameter int W = 432
);
    logic         rx;
    logic [W-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         brk;

    modport master (output rx, input data, valid, frame_err, brk);
    modport slave  (input rx, output data, valid, frame_err, brk);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte deserializer with 2-flop input synchronizer.
//   clk, reset  system clock, async active-high reset
//   rx          raw UART line
//   rx_byte     last byte sampled (valid with any of the strobes below)
//   byte_ok     one-cycle strobe, byte with good stop bit
//   byte_ferr   one-cycle strobe, bad stop bit, nonzero byte
//   byte_break  one-cycle strobe, bad stop bit, zero byte
//   idle        no character in progress
module uart_byte_rx
    import life_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_ferr,
    output logic       byte_break,
    output logic       idle
);
    localparam int CW = $clog2(PERIOD);
    // Counter runs down to 0 and samples there, so loads are one less than
    // the wanted interval: first sample PERIOD/2 clocks after the edge.
    localparam logic [CW-1:0] HALF = CW'(PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(PERIOD - 1);

    logic          rx_s1, rx_s2;
    bit_state_t    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick;

    assign tick = (cnt == '0);
    assign idle = (state == BS_IDLE) || (state == BS_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            state      <= BS_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_ok    <= 1'b0;
            byte_ferr  <= 1'b0;
            byte_break <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            byte_ok    <= 1'b0;
            byte_ferr  <= 1'b0;
            byte_break <= 1'b0;
            case (state)
                BS_IDLE: begin
                    // Falling edge seen one stage early so the FSM reacts on
                    // the same clock rx_s2 goes low.
                    if (rx_s2 && !rx_s1) begin
                        state <= BS_START;
                        cnt   <= HALF;
                    end
                end
                BS_START: begin
                    if (!tick) cnt <= cnt - 1'b1;
                    else if (rx_s2) state <= BS_IDLE;   // glitch
                    else begin
                        state   <= BS_DATA;
                        cnt     <= FULL;
                        bit_idx <= '0;
                    end
                end
                BS_DATA: begin
                    if (!tick) cnt <= cnt - 1'b1;
                    else begin
                        shift <= {rx_s2, shift[7:1]};
                        cnt   <= FULL;
                        if (bit_idx == 3'd7) state <= BS_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end
                end
                BS_STOP: begin
                    if (!tick) cnt <= cnt - 1'b1;
                    else begin
                        rx_byte <= shift;
                        if (rx_s2) begin
                            byte_ok <= 1'b1;
                            state   <= BS_IDLE;
                        end else begin
                            if (shift == 8'h00) byte_break <= 1'b1;
                            else byte_ferr <= 1'b1;
                            state <= BS_WAIT;
                        end
                    end
                end
                BS_WAIT: if (rx_s2) state <= BS_IDLE;
                default: state <= BS_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/life_frame_rx.sv
// life_frame_rx: hunts for the header byte and assembles the life-result
// payload (INIT*INIT pattern bits + 32-bit count) from the UART byte stream.
//   clk, reset  system clock, async active-high reset
//   bus (slave) rx in; data/valid/frame_err/brk out, all registered
module life_frame_rx
    import life_pkg::*;
#(
    parameter int         INIT   = 20,
    parameter int         PERIOD = PERIOD_DEF,
    parameter logic [7:0] HDR    = HDR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    life_frame_rx_if.slave  bus
);
    localparam int W      = INIT * INIT + 32;
    localparam int NBYTES = nbytes(INIT);
    localparam int IW     = $clog2(NBYTES);
    localparam int TMAX   = 16 * PERIOD;
    localparam int TW     = $clog2(TMAX + 1);

    logic [7:0]              rx_byte;
    logic                    byte_ok, byte_ferr, byte_break, idle;
    frame_state_t            fstate;
    logic [IW-1:0]           idx;
    logic [NBYTES-1:0][7:0]  shadow;
    logic [NBYTES*8-1:0]     full_next;
    logic [TW-1:0]           tcnt;
    logic                    timeout;

    uart_byte_rx #(.PERIOD(PERIOD)) u_byte (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus.rx),
        .rx_byte    (rx_byte),
        .byte_ok    (byte_ok),
        .byte_ferr  (byte_ferr),
        .byte_break (byte_break),
        .idle       (idle)
    );

    // Shadow with the final byte merged in, ready to publish.
    always_comb begin
        full_next = shadow;
        full_next[NBYTES*8-1 -: 8] = rx_byte;
    end

    assign timeout = (fstate == FS_PAYLOAD) && idle && (tcnt == TW'(TMAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstate        <= FS_HUNT;
            idx           <= '0;
            shadow        <= '0;
            tcnt          <= '0;
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.brk       <= 1'b0;
        end else begin
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.brk       <= 1'b0;

            // Idle-time counter only matters between payload bytes.
            if (fstate == FS_PAYLOAD && idle && !byte_ok && tcnt != TW'(TMAX))
                tcnt <= tcnt + 1'b1;
            else if (!(fstate == FS_PAYLOAD && idle && !byte_ok))
                tcnt <= '0;

            if (byte_break) begin
                bus.brk <= 1'b1;
                fstate  <= FS_HUNT;
            end else if (byte_ferr) begin
                bus.frame_err <= 1'b1;
                fstate        <= FS_HUNT;
            end else if (byte_ok) begin
                if (fstate == FS_HUNT) begin
                    if (rx_byte == HDR) begin
                        fstate <= FS_PAYLOAD;
                        idx    <= '0;
                    end
                end else begin
                    // A header value here is just payload data.
                    shadow[idx] <= rx_byte;
                    if (idx == IW'(NBYTES - 1)) begin
                        bus.data  <= full_next[W-1:0];
                        bus.valid <= 1'b1;
                        fstate    <= FS_HUNT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            end else if (timeout) begin
                bus.frame_err <= 1'b1;
                fstate        <= FS_HUNT;
                tcnt          <= '0;
            end
        end
    end
endmodule

// File: doc/life_frame_rx.md
# life_frame_rx

Receiver for the life-result frames the board sends over the USB UART: deserializes the 8N1 byte stream, hunts for the frame header, and assembles the INIT*INIT+32-bit result word (pattern bits plus 32-bit count) that the core produces. It is the consumer end of the result link. It sits in a second-board collector or a loopback harness and drives a wide `data` bus with a one-cycle `valid` strobe.

## Interface
- INIT, 20, grid edge; payload width W = INIT*INIT+32
- PERIOD, 434, clocks per UART bit (≥ 4)
- HDR, 8'h4C, frame header byte
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  UART line, idle high, asynchronous to clk
- data  out  W  last complete payload; byte k of the stream carries data[8k+7:8k]
- valid  out  1  one-cycle strobe: data just updated
- frame_err  out  1  one-cycle strobe: stop-bit error or inter-byte timeout aborted a frame
- break  out  1  one-cycle strobe: line held low through a full character (start, 8 data, stop all 0)

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1.
- Bit level, states IDLE/START/DATA/STOP:
  - IDLE → START on synchronized falling edge; the bit counter loads PERIOD/2 (integer divide).
  - START: at the mid-bit sample, rx=1 is a glitch → IDLE with no output. rx=0 → DATA.
  - DATA: 8 samples, one every PERIOD, LSB first.
  - STOP: sample once. rx=1 → byte good. rx=0 with byte 0x00 → break. rx=0 with any other byte → framing error.
  - After any STOP sample, return to IDLE only once rx=1 is seen, so no false start from a held-low line.
- Frame level, states HUNT/PAYLOAD:
  - NBYTES = ceil(W/8). Byte index counts 0..NBYTES-1.
  - HUNT: a good byte equal to HDR → PAYLOAD with index=0. Any other byte is discarded silently.
  - PAYLOAD: each good byte goes into a shadow register at its index. Bits of the last byte above W are ignored.
  - On the last byte, shadow → data, pulse valid, → HUNT.
  - HDR inside the payload is ordinary data and is not treated as a resync.
- Errors:
  - Framing error in any state: pulse frame_err. In PAYLOAD, also abort → HUNT.
  - Break in any state: pulse break, → HUNT. frame_err does not pulse for a break.
  - Inter-byte timeout in PAYLOAD: idle for more than 16*PERIOD clocks between stop sample and next start edge → frame_err, → HUNT.
- data changes only on a complete frame. Aborted frames never alter data.

## Timing
- Reset values: data=0, valid=0, frame_err=0, break=0. Bit FSM=IDLE, frame FSM=HUNT, shadow cleared.
- Reset mid-frame discards the partial frame. Reception restarts from HUNT at the next start edge after reset deasserts.
- The stop-bit sample occurs PERIOD/2 + 9*PERIOD clocks after the synchronized start edge. The synchronized edge lags the rx pin by 2 clocks.
- valid, frame_err and break assert on the clock after the stop-bit sample that causes them. They are registered outputs held for exactly 1 cycle.
- Back-to-back frames with zero idle between stop and next start are accepted. There is no dead time.
- Simultaneous events cannot occur; at most one strobe fires per cycle.
- Counters:
  - Bit counter: $clog2(PERIOD) bits.
  - Timeout counter: $clog2(16*PERIOD+1) bits, saturating.
  - Byte index: $clog2(NBYTES) bits. No wrap-around beyond NBYTES-1.

## Structure
- Shared package `life_pkg`:
  - PERIOD default and HDR.
  - Function nbytes(INIT) returning ceil((INIT*INIT+32)/8).
  - Bit-FSM and frame-FSM state encodings.
- One sub-module `uart_byte_rx`, reused by other receivers:
  - Contains the synchronizer and the bit-level FSM.
  - Outputs byte[7:0], byte_ok, byte_ferr, byte_break and an idle indication for the timeout.
- life_frame_rx holds the frame FSM, shadow register, and timeout counter.

## Test plan
Bench uses INIT=4 (W=48, NBYTES=6) and PERIOD=8.
- Reset, then send 4C 01 02 03 04 05 06 → valid pulses once; data=48'h060504030201; the pulse lands 1 clk after the last stop sample.
- Send 00 55 4C, then six bytes FF → first two bytes ignored; data=48'hFFFFFFFFFFFF.
- Send 4C 11 22 with bad stop on the next byte, then 4C 01..06 → frame_err pulse; data updates only to 48'h060504030201.
- Mid-payload, hold rx low for 12*PERIOD → one break pulse; no valid; the next good frame is received normally.
- Send a 2-clock low glitch in IDLE → no byte, no strobe. Also leave a 17*PERIOD gap after the third payload byte → frame_err, then HUNT.
- Assert reset during the fourth payload byte → all outputs 0. A following full frame is received correctly.
